// File: rtl/spi_msg_ctrl_if.sv
// Byte-interface and register-bus signals of the SPI message controller.
// The controller connects through master; the byte interface and register file connect through slave.
interface spi_msg_ctrl_if;
  logic       ssActive;
  logic       byteRxValid;
  logic [7:0] byteRx;
  logic [7:0] byteTx;
  logic [6:0] regAddr;
  logic       regWrEn;
  logic [7:0] regWrData;
  logic       regRdEn;
  logic [7:0] regRdData;
  logic       msgActive;
  logic       msgDone;
  logic [7:0] byteCount;
  logic       overrun;

  modport master (
    input  ssActive, byteRxValid, byteRx, regRdData,
    output byteTx, regAddr, regWrEn, regWrData, regRdEn,
    output msgActive, msgDone, byteCount, overrun
  );

  modport slave (
    output ssActive, byteRxValid, byteRx, regRdData,
    input  byteTx, regAddr, regWrEn, regWrData, regRdEn,
    input  msgActive, msgDone, byteCount, overrun
  );
endinterface

// File: rtl/spi_msg_ctrl.sv
// SPI message controller: decodes {rw, addr} command bytes and streams
// register reads/writes with auto-incrementing address.
module spi_msg_ctrl #(
  parameter logic [7:0] STATUS_BYTE = 8'hA5,
  parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
  input  logic          sysClk,
  input  logic          usrReset,
  spi_msg_ctrl_if.master bus_io
);

  typedef enum logic [2:0] {StIdle, StCmd, StWrite, StFetch, StRead} state_e;

  state_e     state_q, state_d;
  logic       ss_q, ss_d;
  logic       fetch_wait_q, fetch_wait_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] byte_tx_q, byte_tx_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] count_q, count_d;
  logic       overrun_q, overrun_d;
  logic       rx_ok;

  // A byte coinciding with slave-select deassertion is dropped.
  assign rx_ok = bus_io.ssActive && bus_io.byteRxValid && (state_q != StIdle);

  always_ff @(posedge sysClk or posedge usrReset) begin
    if (usrReset) begin
      state_q      <= StIdle;
      ss_q         <= 1'b1;  // forces a fresh rising edge after reset
      fetch_wait_q <= 1'b0;
      addr_q       <= 7'd0;
      byte_tx_q    <= STATUS_BYTE;
      wr_en_q      <= 1'b0;
      wr_data_q    <= 8'd0;
      count_q      <= 8'd0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ss_q         <= ss_d;
      fetch_wait_q <= fetch_wait_d;
      addr_q       <= addr_d;
      byte_tx_q    <= byte_tx_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      count_q      <= count_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ss_d         = bus_io.ssActive;
    fetch_wait_d = fetch_wait_q;
    addr_d       = addr_q;
    byte_tx_d    = byte_tx_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    count_d      = count_q;
    overrun_d    = overrun_q;

    if (rx_ok && (count_q != 8'hFF)) count_d = count_q + 8'd1;
    // Address advances in the cycle after the write strobe is issued.
    if (wr_en_q) addr_d = addr_q + 7'd1;

    unique case (state_q)
      StIdle: begin
        byte_tx_d = STATUS_BYTE;
        if (bus_io.ssActive && !ss_q) begin
          state_d   = StCmd;
          count_d   = 8'd0;
          overrun_d = 1'b0;
        end
      end
      StCmd: begin
        if (rx_ok) begin
          addr_d       = bus_io.byteRx[6:0];
          fetch_wait_d = 1'b0;
          if (bus_io.byteRx[7]) begin
            state_d = StFetch;
          end else begin
            state_d   = StWrite;
            byte_tx_d = FILL_BYTE;
          end
        end
      end
      StWrite: begin
        if (rx_ok) begin
          wr_en_d   = 1'b1;
          wr_data_d = bus_io.byteRx;
        end
      end
      StFetch: begin
        if (rx_ok) overrun_d = 1'b1;
        if (fetch_wait_q) begin
          byte_tx_d    = bus_io.regRdData;
          state_d      = StRead;
          fetch_wait_d = 1'b0;
        end else begin
          fetch_wait_d = 1'b1;
        end
      end
      StRead: begin
        if (rx_ok) begin
          addr_d       = addr_q + 7'd1;
          state_d      = StFetch;
          fetch_wait_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!bus_io.ssActive) begin
      state_d      = StIdle;
      byte_tx_d    = STATUS_BYTE;
      fetch_wait_d = 1'b0;
    end
  end

  always_comb begin
    bus_io.msgActive = (state_q != StIdle);
    bus_io.msgDone   = (state_q != StIdle) && !bus_io.ssActive && (count_q != 8'd0);
    bus_io.regRdEn   = (state_q == StFetch) && !fetch_wait_q && bus_io.ssActive;
    bus_io.regWrEn   = wr_en_q;
    bus_io.regAddr   = addr_q;
    bus_io.regWrData = wr_data_q;
    bus_io.byteTx    = byte_tx_q;
    bus_io.byteCount = count_q;
    bus_io.overrun   = overrun_q;
  end

endmodule

// File: tb/tb_spi_msg_ctrl.sv
// Directed bench for spi_msg_ctrl with a small register-file model.
module tb_spi_msg_ctrl;
  logic sysClk;
  logic usrReset;
  int   compared;
  int   mismatched;
  int   wr_cnt;
  int   done_cnt;
  logic [7:0] mem [128];

  spi_msg_ctrl_if bus ();

  spi_msg_ctrl dut (
    .sysClk  (sysClk),
    .usrReset(usrReset),
    .bus_io  (bus)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sysClk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.byteRxValid = 1'b1;
    bus.byteRx      = b;
    step();
    bus.byteRxValid = 1'b0;
  endtask

  // Register file: read data valid one cycle after the read strobe.
  always @(posedge sysClk) begin
    if (bus.regRdEn) bus.regRdData <= mem[bus.regAddr];
    if (bus.regWrEn) begin
      mem[bus.regAddr] <= bus.regWrData;
      wr_cnt++;
    end
    if (bus.msgDone) done_cnt++;
    if (bus.regWrEn && bus.regRdEn) check("wr_rd_exclusive", 32'd1, 32'd0);
  end

  initial begin
    compared = 0; mismatched = 0; wr_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[7'h10] = 8'hAB;
    mem[7'h11] = 8'hCD;
    bus.regRdData   = 8'h00;
    usrReset        = 1'b1;
    bus.ssActive    = 1'b0;
    bus.byteRxValid = 1'b0;
    bus.byteRx      = 8'h00;
    #1;
    check("rst_byteTx", bus.byteTx, 8'hA5);
    check("rst_regAddr", bus.regAddr, 0);
    check("rst_wr_rd_en", {bus.regWrEn, bus.regRdEn}, 0);
    check("rst_active_done", {bus.msgActive, bus.msgDone}, 0);
    check("rst_count_ovr", {bus.byteCount, bus.overrun}, 0);
    step(); step();
    usrReset = 1'b0;
    step(); step();

    // Write 0x11 @5, 0x22 @6
    bus.ssActive = 1'b1; step();
    check("wr_cmd_active", bus.msgActive, 1);
    check("wr_cmd_tx", bus.byteTx, 8'hA5);
    send(8'h05);
    check("wr_fill_tx", bus.byteTx, 8'hFF);
    send(8'h11);
    check("wr1_strobe", {bus.regWrEn, 1'b0, bus.regAddr, bus.regWrData}, {1'b1, 1'b0, 7'h05, 8'h11});
    step();
    send(8'h22);
    check("wr2_strobe", {bus.regWrEn, 1'b0, bus.regAddr, bus.regWrData}, {1'b1, 1'b0, 7'h06, 8'h22});
    check("wr_count", bus.byteCount, 3);
    step();
    bus.ssActive = 1'b0; #1;
    check("wr_done_pulse", bus.msgDone, 1);
    step();
    check("wr_idle", {bus.msgDone, bus.msgActive, bus.byteTx}, {2'b00, 8'hA5});
    check("wr_done_cnt", done_cnt, 1);
    check("wr_cnt1", wr_cnt, 2);
    check("wr_mem", {mem[5], mem[6]}, 16'h1122);

    // Read from 0x10, 0x11
    bus.ssActive = 1'b1; step();
    send(8'h90);
    check("rd_strobe", {bus.regRdEn, bus.regAddr}, {1'b1, 7'h10});
    step(); step();
    check("rd_tx_AB", bus.byteTx, 8'hAB);
    send(8'h00);
    step(); step();
    check("rd_tx_CD", bus.byteTx, 8'hCD);
    send(8'h00);
    step(); step();
    check("rd_count", bus.byteCount, 3);
    bus.ssActive = 1'b0; step();
    check("rd_done_cnt", done_cnt, 2);

    // Address wrap 0x7F -> 0x00
    bus.ssActive = 1'b1; step();
    send(8'h7F);
    send(8'hAA);
    check("wrap_wr1", {bus.regWrEn, bus.regAddr, bus.regWrData}, {1'b1, 7'h7F, 8'hAA});
    step();
    send(8'hBB);
    check("wrap_wr2", {bus.regWrEn, bus.regAddr, bus.regWrData}, {1'b1, 7'h00, 8'hBB});
    step();
    bus.ssActive = 1'b0; step();
    check("wrap_wr_cnt", wr_cnt, 4);

    // Overrun during fetch
    bus.ssActive = 1'b1; step();
    bus.byteRxValid = 1'b1; bus.byteRx = 8'h90; step();
    bus.byteRx = 8'h33; step();
    bus.byteRxValid = 1'b0;
    check("ovr_flag_count", {bus.overrun, bus.byteCount}, {1'b1, 8'd2});
    step();
    check("ovr_fetch_done", bus.byteTx, 8'hAB);
    bus.ssActive = 1'b0; step();
    check("ovr_sticky", bus.overrun, 1);
    bus.ssActive = 1'b1; step();
    check("ovr_clear", {bus.overrun, bus.byteCount}, 0);

    // Deassertion coincides with a data byte
    send(8'h20);
    bus.byteRxValid = 1'b1; bus.byteRx = 8'h44; bus.ssActive = 1'b0; #1;
    check("sim_done_pulse", bus.msgDone, 1);
    step();
    bus.byteRxValid = 1'b0;
    step();
    check("sim_no_write", wr_cnt, 4);
    check("sim_count", {bus.byteCount, bus.msgActive}, {8'd1, 1'b0});
    check("sim_done_cnt", done_cnt, 5);

    // Reset mid-write
    bus.ssActive = 1'b1; step();
    send(8'h30);
    usrReset = 1'b1; bus.byteRxValid = 1'b1; bus.byteRx = 8'h55; #1;
    check("mrst_outs", {bus.byteTx, bus.regAddr, bus.regWrData, bus.regWrEn, bus.regRdEn},
          {8'hA5, 7'h00, 8'h00, 2'b00});
    check("mrst_status", {bus.msgActive, bus.msgDone, bus.byteCount, bus.overrun}, 0);
    step();
    bus.byteRxValid = 1'b0;
    step();
    check("mrst_no_wr_done", {wr_cnt[15:0], done_cnt[15:0]}, {16'd4, 16'd5});
    usrReset = 1'b0; step(); step();
    check("mrst_wait_edge", bus.msgActive, 0);
    bus.ssActive = 1'b0; step();
    bus.ssActive = 1'b1; step();
    check("mrst_fresh_edge", bus.msgActive, 1);
    bus.ssActive = 1'b0; step();
    check("empty_no_done", done_cnt, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
